mac_acc_drain: RTL and testbench
================================

# mac_acc_drain

Output drain stage that sits directly downstream of the MAC accumulator block. On a capture strobe it snapshots the four accumulator lanes (`out0`..`out3`) and streams the 4×`MAC_ACC_WIDTH`-bit result out as `MAC_MIN_WIDTH`-bit beats over a valid/ready interface. A last flag marks the end of each logical result according to the captured Single/Dual/Quad mode. Captures that arrive while a stream is in flight are dropped and flagged.

## Interface
- `MAC_MIN_WIDTH`, default 8: beat width in bits.
- `MAC_ACC_WIDTH`, default 4*MAC_MIN_WIDTH: width of one accumulator lane; must be a multiple of `MAC_MIN_WIDTH`.
- `clk`  input  1: single clock; all state changes on its rising edge.
- `rst_n`  input  1: reset, asynchronous and active-low.
- `mode`  input  2: lane grouping, encoded with `MAC_SINGLE` / `MAC_DUAL` / `MAC_QUAD` from mac_const.vh (same as accumulator cfg[1:0]). Any other value is treated as `MAC_SINGLE`.
- `capture`  input  1: snapshot request.
- `in0`..`in3`  input  MAC_ACC_WIDTH each: accumulator lanes; `in0` is least significant.
- `busy`  output  1: stream in flight.
- `out_data`  output  MAC_MIN_WIDTH: current beat.
- `out_valid`  output  1: beat valid.
- `out_ready`  input  1: consumer accepts the beat.
- `out_last`  output  1: current beat is the final beat of a logical result.
- `drop`  output  1: sticky flag, set when a capture was ignored.
- `drop_clr`  input  1: clears `drop`.

## Operation
- Definitions:
  - B = MAC_ACC_WIDTH/MAC_MIN_WIDTH (beats per lane).
  - N = 4·B (beats per stream).
  - G = B for single, 2B for dual, 4B for quad (beats per result).
- FSM has two states, IDLE and SEND.
- IDLE:
  - `busy`=0 and `out_valid`=0.
  - When `capture`=1:
    - load the 4·MAC_ACC_WIDTH shift register with {in3,in2,in1,in0};
    - latch `mode`;
    - clear the beat counter `cnt`;
    - go to SEND.
- SEND:
  - `busy`=1 and `out_valid`=1.
  - `out_data` = shift register bits [MAC_MIN_WIDTH-1:0].
  - `out_last` = ((cnt+1) mod G == 0), using the latched mode.
  - On a handshake (`out_valid` & `out_ready`):
    - shift right by MAC_MIN_WIDTH and increment `cnt`;
    - if `cnt` == N-1, the stream is complete.
- Stream completion:
  - If `capture`=1 in the same cycle, reload and stay in SEND with `cnt`=0 (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Drop rule: `drop` is set when `capture`=1 in SEND and that cycle is not the completing handshake. The stream is unaffected.
- `drop_clr`: clears `drop`. If a drop and a clear occur in the same cycle, set wins.
- Mode changes during SEND have no effect until the next capture.
- Byte order: least-significant beat first. In dual mode the result {in1,in0} streams before {in3,in2}.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately):
  - state=IDLE;
  - `busy`=0, `out_valid`=0, `out_last`=0, `drop`=0;
  - `out_data`=0, `cnt`=0, shift register=0.
  - Reset asserted mid-stream aborts the stream with no further beats. The first capture after release starts a fresh stream.
- Capture latency:
  - capture sampled at edge k → `out_valid`=1 with beat 0 after edge k;
  - `in0`..`in3` are sampled only at edge k.
- Hold rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` are held stable.
- Throughput: one beat per cycle with `out_ready` held high, so a stream takes N cycles; with back-to-back captures the bus is 100% utilised.
- Registered outputs: `out_valid`, `busy`, `out_last`, `out_data` and `drop` are registered or decoded from registered state only; there is no combinational path from `out_ready`.
- `drop` rises on the edge after the offending capture.

## Test plan
Defaults MIN=8, ACC=32 (B=4, N=16). Lane inputs: in0=0x04030201, in1=0x08070605, in2=0x0C0B0A09, in3=0x100F0E0D.

- Single mode, `out_ready`=1, one capture:
  - beats 0x01..0x10 on 16 consecutive cycles;
  - `out_last` on beats 4, 8, 12, 16;
  - `busy` falls after beat 16.
- Dual mode, same data: `out_last` only on beats 8 and 16. Quad mode: `out_last` only on beat 16. Changing `mode` mid-stream does not change the pattern.
- Backpressure, single mode:
  - drop `out_ready` for 3 cycles while beat 5 is presented;
  - `out_data` holds 0x05 and `out_valid` stays 1;
  - resumes with 0x06; total stream length is 19 cycles.
- Back-to-back:
  - assert `capture` on the cycle of the beat-16 handshake, with new in0=0xDDCCBBAA;
  - next cycle shows 0xAA with no idle cycle and `drop` stays 0.
- Drop handling:
  - capture at beat 3 → `drop`=1 and the stream continues 0x04, 0x05… unaltered;
  - `drop_clr` alone → `drop`=0;
  - `drop_clr` together with a new mid-stream capture → `drop`=1.
- Reset mid-stream:
  - assert `rst_n`=0 during beat 7 → `out_valid`, `busy` and `drop` go to 0 before the next clock edge;
  - after release, a capture streams from 0x01 again.

Source files
------------

// File: rtl/mac_acc_drain.sv
// mac_acc_drain: snapshot four accumulator lanes and stream them out as narrow valid/ready beats
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_mode[1:0]                 lane grouping (single/dual/quad), latched on capture
//   i_capture                   snapshot request
//   i_in0..i_in3                accumulator lanes, i_in0 least significant
//   o_busy                      stream in flight
//   o_out_data, o_out_valid     current beat, beat valid
//   i_out_ready                 consumer accepts beat
//   o_out_last                  final beat of a logical result
//   o_drop, i_drop_clr          sticky ignored-capture flag and its clear
module mac_acc_drain #(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_ACC_WIDTH = 4*MAC_MIN_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               i_mode,
  input  logic                     i_capture,
  input  logic [MAC_ACC_WIDTH-1:0] i_in0,
  input  logic [MAC_ACC_WIDTH-1:0] i_in1,
  input  logic [MAC_ACC_WIDTH-1:0] i_in2,
  input  logic [MAC_ACC_WIDTH-1:0] i_in3,
  output logic                     o_busy,
  output logic [MAC_MIN_WIDTH-1:0] o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_last,
  output logic                     o_drop,
  input  logic                     i_drop_clr
);
  localparam logic [1:0] MAC_SINGLE = 2'd0;
  localparam logic [1:0] MAC_DUAL   = 2'd1;
  localparam logic [1:0] MAC_QUAD   = 2'd2;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;
  localparam int B  = MAC_ACC_WIDTH / MAC_MIN_WIDTH;
  localparam int N  = 4 * B;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW:0]   G1 = (CW+1)'(B);
  localparam logic [CW:0]   G2 = (CW+1)'(2 * B);
  logic [0:0]                 r_state;
  logic [4*MAC_ACC_WIDTH-1:0] r_sr;
  logic [1:0]                 r_mode;
  logic [CW-1:0]              r_cnt;
  logic                       r_drop;
  logic                       w_send;
  logic                       w_hs;
  logic                       w_done;
  logic                       w_load;
  logic [CW:0]                w_cnt1;
  always_comb begin
    w_send = (r_state == SEND);
    w_hs   = w_send & i_out_ready;
    w_done = w_hs & (r_cnt == LAST_CNT);
    // a capture is accepted when idle or exactly on the completing handshake
    w_load = i_capture & (~w_send | w_done);
    w_cnt1 = {1'b0, r_cnt} + 1'b1;
  end
  assign o_busy      = w_send;
  assign o_out_valid = w_send;
  assign o_out_data  = r_sr[MAC_MIN_WIDTH-1:0];
  assign o_drop      = r_drop;
  // unknown mode encodings fall back to single grouping
  assign o_out_last  = w_send & ((r_mode == MAC_QUAD) ? (r_cnt == LAST_CNT) :
                                 (r_mode == MAC_DUAL) ? ((w_cnt1 % G2) == '0) :
                                                        ((w_cnt1 % G1) == '0));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_mode  <= MAC_SINGLE;
      r_cnt   <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_load ? SEND : w_done ? IDLE : r_state;
      r_sr    <= w_load ? {i_in3, i_in2, i_in1, i_in0} : w_hs ? (r_sr >> MAC_MIN_WIDTH) : r_sr;
      r_mode  <= w_load ? i_mode : r_mode;
      r_cnt   <= (w_load | w_done) ? '0 : w_hs ? w_cnt1[CW-1:0] : r_cnt;
      // a new drop takes priority over a simultaneous clear
      r_drop  <= (w_send & i_capture & ~w_done) | (r_drop & ~i_drop_clr);
    end
  end
endmodule

// File: tb/tb_mac_acc_drain.sv
// tb_mac_acc_drain: directed self-checking bench for mac_acc_drain
module tb_mac_acc_drain;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic        i_capture = 1'b0;
  logic [31:0] i_in0 = 32'h04030201;
  logic [31:0] i_in1 = 32'h08070605;
  logic [31:0] i_in2 = 32'h0C0B0A09;
  logic [31:0] i_in3 = 32'h100F0E0D;
  logic        o_busy;
  logic [7:0]  o_out_data;
  logic        o_out_valid;
  logic        i_out_ready = 1'b1;
  logic        o_out_last;
  logic        o_drop;
  logic        i_drop_clr = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc;
  mac_acc_drain dut (
    .clk(clk), .rst_n(rst_n), .i_mode(i_mode), .i_capture(i_capture),
    .i_in0(i_in0), .i_in1(i_in1), .i_in2(i_in2), .i_in3(i_in3),
    .o_busy(o_busy), .o_out_data(o_out_data), .o_out_valid(o_out_valid),
    .i_out_ready(i_out_ready), .o_out_last(o_out_last), .o_drop(o_drop),
    .i_drop_clr(i_drop_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drain;
    for (int k = 0; k < 40 && o_busy; k++) tick();
    chk("drain_idle", {31'd0, o_busy}, 32'd0);
  endtask
  task automatic run_stream(input logic [1:0] m, input int g, input string tag);
    i_mode = m;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) i_mode = (m == 2'd2) ? 2'd0 : 2'd2;
      chk({tag, "_data"}, {24'd0, o_out_data}, i + 1);
      chk({tag, "_valid"}, {31'd0, o_out_valid}, 32'd1);
      chk({tag, "_last"}, {31'd0, o_out_last}, {31'd0, ((i + 1) % g) == 0});
      tick();
    end
    chk({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_valid_end"}, {31'd0, o_out_valid}, 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_last", {31'd0, o_out_last}, 32'd0);
    chk("rst_drop", {31'd0, o_drop}, 32'd0);
    chk("rst_data", {24'd0, o_out_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_valid", {31'd0, o_out_valid}, 32'd0);
    run_stream(2'd0, 4, "single");
    run_stream(2'd1, 8, "dual");
    run_stream(2'd2, 16, "quad");
    i_mode = 2'd0;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    cyc = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        i_out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          chk("bp_hold_data", {24'd0, o_out_data}, 32'h05);
          chk("bp_hold_valid", {31'd0, o_out_valid}, 32'd1);
          chk("bp_hold_last", {31'd0, o_out_last}, 32'd0);
          tick();
          cyc++;
        end
        i_out_ready = 1'b1;
      end
      chk("bp_data", {24'd0, o_out_data}, i + 1);
      tick();
      cyc++;
    end
    chk("bp_length", cyc, 32'd19);
    chk("bp_busy_end", {31'd0, o_busy}, 32'd0);
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("b2b_beat16", {24'd0, o_out_data}, 32'h10);
    i_capture = 1'b1;
    i_in0 = 32'hDDCCBBAA;
    tick();
    i_capture = 1'b0;
    chk("b2b_data", {24'd0, o_out_data}, 32'hAA);
    chk("b2b_valid", {31'd0, o_out_valid}, 32'd1);
    chk("b2b_drop", {31'd0, o_drop}, 32'd0);
    tick();
    chk("b2b_data2", {24'd0, o_out_data}, 32'hBB);
    drain();
    i_in0 = 32'h04030201;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        chk("drop_beat3", {24'd0, o_out_data}, 32'h03);
        i_capture = 1'b1;
        i_in0 = 32'hFFFFFFFF;
        tick();
        i_capture = 1'b0;
        i_in0 = 32'h04030201;
        chk("drop_set", {31'd0, o_drop}, 32'd1);
        continue;
      end
      chk("drop_stream", {24'd0, o_out_data}, i + 1);
      tick();
    end
    chk("drop_busy_end", {31'd0, o_busy}, 32'd0);
    chk("drop_sticky", {31'd0, o_drop}, 32'd1);
    i_drop_clr = 1'b1;
    tick();
    i_drop_clr = 1'b0;
    chk("drop_clr", {31'd0, o_drop}, 32'd0);
    i_capture = 1'b1;
    tick();
    tick();
    chk("drop_clr_both_pre", {31'd0, o_drop}, 32'd1);
    i_capture = 1'b1;
    i_drop_clr = 1'b1;
    tick();
    i_capture = 1'b0;
    i_drop_clr = 1'b0;
    chk("drop_clr_both", {31'd0, o_drop}, 32'd1);
    drain();
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_mid_beat7", {24'd0, o_out_data}, 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, o_out_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_drop", {31'd0, o_drop}, 32'd0);
    tick();
    chk("rst_hold_valid", {31'd0, o_out_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {31'd0, o_out_valid}, 32'd0);
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    chk("post_rst_data", {24'd0, o_out_data}, 32'h01);
    chk("post_rst_valid", {31'd0, o_out_valid}, 32'd1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
